// File: rtl/bot_int_ack_ctrl_pkg.sv
// Shared types and constants for the RojoBot update acknowledge controller.
package bot_int_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    PENDING,
    ACK,
    WAIT_CLR
  } state_e;

  localparam int unsigned        STAT_W   = 8;
  localparam logic [STAT_W-1:0]  MISS_SAT = 8'd255;

endpackage

// File: rtl/bot_int_ack_ctrl_if.sv
// Handshake, status and snapshot signals between the bot interface and the CPU side.
interface bot_int_ack_ctrl_if;
  import bot_int_pkg::*;

  logic              IO_BotUpdt_Sync;
  logic              IO_BotUpdt;
  logic [STAT_W-1:0] LocX, LocY, Sensors, BotInfo;
  logic              sw_ack_wr;
  logic              IO_INT_ACK;
  logic              irq;
  logic [STAT_W-1:0] snap_LocX, snap_LocY, snap_Sensors, snap_BotInfo;
  logic              ack_err;
  logic [STAT_W-1:0] miss_cnt;

  modport master (
    output IO_BotUpdt_Sync, IO_BotUpdt, LocX, LocY, Sensors, BotInfo, sw_ack_wr,
    input  IO_INT_ACK, irq, snap_LocX, snap_LocY, snap_Sensors, snap_BotInfo,
           ack_err, miss_cnt
  );

  modport slave (
    input  IO_BotUpdt_Sync, IO_BotUpdt, LocX, LocY, Sensors, BotInfo, sw_ack_wr,
    output IO_INT_ACK, irq, snap_LocX, snap_LocY, snap_Sensors, snap_BotInfo,
           ack_err, miss_cnt
  );

endinterface

// File: rtl/bot_int_ack_ctrl_snap.sv
// Four-byte status snapshot register with a shared load enable.
module bot_snap_reg
  import bot_int_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_i,
  input  logic [STAT_W-1:0] locx_i,
  input  logic [STAT_W-1:0] locy_i,
  input  logic [STAT_W-1:0] sensors_i,
  input  logic [STAT_W-1:0] botinfo_i,
  output logic [STAT_W-1:0] locx_o,
  output logic [STAT_W-1:0] locy_o,
  output logic [STAT_W-1:0] sensors_o,
  output logic [STAT_W-1:0] botinfo_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locx_o    <= '0;
      locy_o    <= '0;
      sensors_o <= '0;
      botinfo_o <= '0;
    end else if (ld_i) begin
      locx_o    <= locx_i;
      locy_o    <= locy_i;
      sensors_o <= sensors_i;
      botinfo_o <= botinfo_i;
    end
  end

endmodule

// File: rtl/bot_int_ack_ctrl.sv
// RojoBot update consumer: snapshot status, interrupt the CPU, acknowledge with retry.
// Optional BOT_MISS_CNT_EN counts raw updates that arrive while one is still in flight.
module bot_int_ack_ctrl
  import bot_int_pkg::*;
#(
  parameter int unsigned CLR_TIMEOUT = 16,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk50,
  input  logic              reset,
  bot_int_ack_ctrl_if.slave bus
);

  localparam int unsigned TMO_W = (CLR_TIMEOUT > 2) ? $clog2(CLR_TIMEOUT) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CLR_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_e           state_q;
  logic [TMO_W-1:0] tmo_q;
  logic [RTY_W-1:0] rty_q;
  logic             irq_q, ack_q, err_q;
  logic             snap_ld;

  // ack_q is set on entry to ACK so the pulse coincides with the ACK state.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      rty_q   <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.IO_BotUpdt_Sync) state_q <= CAPTURE;
        CAPTURE: begin
          irq_q   <= 1'b1;
          state_q <= PENDING;
        end
        PENDING: if (bus.sw_ack_wr) begin
          irq_q   <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          ack_q   <= 1'b0;
          tmo_q   <= '0;
          state_q <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!bus.IO_BotUpdt_Sync) begin
            rty_q   <= '0;
            state_q <= IDLE;
          end else if (tmo_q == TMO_LAST) begin
            if (rty_q < RTY_MAX) begin
              rty_q   <= rty_q + 1'b1;
              ack_q   <= 1'b1;
              state_q <= ACK;
            end else begin
              err_q   <= 1'b1;
              rty_q   <= '0;
              state_q <= IDLE;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign snap_ld        = (state_q == CAPTURE);
  assign bus.irq        = irq_q;
  assign bus.IO_INT_ACK = ack_q;
  assign bus.ack_err    = err_q;

  bot_snap_reg u_snap (
    .clk_i     (clk50),
    .rst_i     (reset),
    .ld_i      (snap_ld),
    .locx_i    (bus.LocX),
    .locy_i    (bus.LocY),
    .sensors_i (bus.Sensors),
    .botinfo_i (bus.BotInfo),
    .locx_o    (bus.snap_LocX),
    .locy_o    (bus.snap_LocY),
    .sensors_o (bus.snap_Sensors),
    .botinfo_o (bus.snap_BotInfo)
  );

`ifdef BOT_MISS_CNT_EN
  logic              updt_q;
  logic [STAT_W-1:0] miss_q, miss_d;

  always_comb begin
    miss_d = miss_q;
    if (bus.IO_BotUpdt && !updt_q && (state_q != IDLE) && (miss_q != MISS_SAT))
      miss_d = miss_q + 1'b1;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      updt_q <= 1'b0;
      miss_q <= '0;
    end else begin
      updt_q <= bus.IO_BotUpdt;
      miss_q <= miss_d;
    end
  end

  assign bus.miss_cnt = miss_q;
`else
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_bot_int_ack_ctrl.sv
// Self-checking bench for bot_int_ack_ctrl; snapshot expectations go through a scoreboard queue.
module tb_bot_int_ack_ctrl;

  logic clk50 = 1'b0;
  logic reset = 1'b1;

  bot_int_ack_ctrl_if bif ();

  bot_int_ack_ctrl #(.CLR_TIMEOUT(16), .MAX_RETRY(3)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic [7:0] x, y, s, b;
  } snap_t;

  snap_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    miss_model = 0;

  task automatic raise_update(input logic [7:0] x, y, s, b);
    snap_t e;
    bif.LocX = x; bif.LocY = y; bif.Sensors = s; bif.BotInfo = b;
    bif.IO_BotUpdt_Sync = 1'b1;
    e.x = x; e.y = y; e.s = s; e.b = b;
    sb_q.push_back(e);
  endtask

  // Wait for irq, check its latency in cycles, then pop and compare the snapshot.
  task automatic expect_capture(input int lat);
    int    seen;
    snap_t e;
    seen = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk50);
      if (bif.irq === 1'b1) begin
        seen = i;
        break;
      end
    end
    n_vec++;
    if (seen != lat) begin
      n_err++;
      $display("FAIL irq_latency: got %0d cycles, expected %0d", seen, lat);
    end
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL snapshot_sb: scoreboard empty, expected an entry");
    end else begin
      e = sb_q.pop_front();
      if ({bif.snap_LocX, bif.snap_LocY, bif.snap_Sensors, bif.snap_BotInfo} !==
          {e.x, e.y, e.s, e.b}) begin
        n_err++;
        $display("FAIL snapshot: got %h_%h_%h_%h, expected %h_%h_%h_%h",
                 bif.snap_LocX, bif.snap_LocY, bif.snap_Sensors, bif.snap_BotInfo,
                 e.x, e.y, e.s, e.b);
      end
    end
  endtask

  // Software ack, check the single ACK pulse, then the handshake flip-flop clears Sync.
  task automatic ack_and_clear();
    bif.sw_ack_wr = 1'b1;
    @(negedge clk50);
    bif.sw_ack_wr = 1'b0;
    n_vec++;
    if (bif.IO_INT_ACK !== 1'b1 || bif.irq !== 1'b0) begin
      n_err++;
      $display("FAIL ack_pulse: ack=%b irq=%b, expected ack=1 irq=0", bif.IO_INT_ACK, bif.irq);
    end
    @(negedge clk50);
    n_vec++;
    if (bif.IO_INT_ACK !== 1'b0) begin
      n_err++;
      $display("FAIL ack_width: ack=%b one cycle later, expected 0", bif.IO_INT_ACK);
    end
    bif.IO_BotUpdt_Sync = 1'b0;
  endtask

  task automatic pulse_updt(input int n);
    for (int i = 0; i < n; i++) begin
      bif.IO_BotUpdt = 1'b1;
      @(negedge clk50);
      bif.IO_BotUpdt = 1'b0;
      @(negedge clk50);
    end
  endtask

  task automatic check_miss(input string tag);
    int exp_v;
`ifdef BOT_MISS_CNT_EN
    exp_v = miss_model;
`else
    exp_v = 0;
`endif
    n_vec++;
    if (bif.miss_cnt !== 8'(exp_v)) begin
      n_err++;
      $display("FAIL miss_%s: got %0d, expected %0d", tag, bif.miss_cnt, exp_v);
    end
  endtask

  task automatic test_reset();
    bif.IO_BotUpdt_Sync = 1'b0; bif.IO_BotUpdt = 1'b0; bif.sw_ack_wr = 1'b0;
    bif.LocX = '0; bif.LocY = '0; bif.Sensors = '0; bif.BotInfo = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk50);
    n_vec++;
    if ({bif.irq, bif.IO_INT_ACK, bif.ack_err, bif.snap_LocX, bif.snap_LocY,
         bif.snap_Sensors, bif.snap_BotInfo, bif.miss_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_state: irq=%b ack=%b err=%b snaps=%h%h%h%h miss=%0d, expected all 0",
               bif.irq, bif.IO_INT_ACK, bif.ack_err, bif.snap_LocX, bif.snap_LocY,
               bif.snap_Sensors, bif.snap_BotInfo, bif.miss_cnt);
    end
    reset = 1'b0;
    @(negedge clk50);
  endtask

  task automatic test_handshake();
    int acks;
    raise_update(8'h12, 8'h34, 8'h5A, 8'h07);
    expect_capture(2);
    bif.LocX = 8'hFF;
    repeat (3) @(negedge clk50);
    n_vec++;
    if (bif.snap_LocX !== 8'h12 || bif.irq !== 1'b1) begin
      n_err++;
      $display("FAIL snap_stable_pending: snap_LocX=%h irq=%b, expected 12 and 1", bif.snap_LocX, bif.irq);
    end
    ack_and_clear();
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50);
      if (bif.IO_INT_ACK === 1'b1) acks++;
    end
    n_vec++;
    if (acks != 0 || bif.irq !== 1'b0 || bif.snap_LocX !== 8'h12) begin
      n_err++;
      $display("FAIL idle_after_clear: acks=%0d irq=%b snap_LocX=%h, expected 0 0 12",
               acks, bif.irq, bif.snap_LocX);
    end
    bif.sw_ack_wr = 1'b1;
    @(negedge clk50);
    bif.sw_ack_wr = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk50);
      if (bif.IO_INT_ACK === 1'b1 || bif.irq === 1'b1) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL stray_sw_ack: %0d active cycles, expected 0", acks);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    raise_update(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    expect_capture(2);
    ack_and_clear();
    @(negedge clk50);
    raise_update(8'h11, 8'h22, 8'h33, 8'h44);
    expect_capture(2);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk50);
      if (bif.IO_INT_ACK === 1'b1) acks++;
    end
    n_vec++;
    if (acks != 0 || bif.irq !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_hold: acks=%0d irq=%b, expected 0 and 1", acks, bif.irq);
    end
    ack_and_clear();
    repeat (2) @(negedge clk50);
  endtask

  task automatic test_stuck_flag();
    int pulses[$];
    int err_at;
    raise_update(8'h5C, 8'h6D, 8'h7E, 8'h8F);
    expect_capture(2);
    bif.sw_ack_wr = 1'b1;
    err_at = -1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk50);
      bif.sw_ack_wr = 1'b0;
      if (bif.IO_INT_ACK === 1'b1) pulses.push_back(i);
      if (bif.ack_err === 1'b1) begin
        err_at = i;
        break;
      end
    end
    n_vec++;
    if (pulses.size() != 4) begin
      n_err++;
      $display("FAIL stuck_pulse_count: got %0d, expected 4", pulses.size());
    end
    for (int k = 1; k < pulses.size(); k++) begin
      n_vec++;
      if (pulses[k] - pulses[k-1] != 17) begin
        n_err++;
        $display("FAIL stuck_spacing: pulse %0d spacing %0d, expected 17", k, pulses[k] - pulses[k-1]);
      end
    end
    n_vec++;
    if (err_at < 0 || pulses.size() == 0 || err_at - pulses[pulses.size()-1] != 17 || bif.irq !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_err: err_at=%0d irq=%b, expected 17 cycles after last ack and irq 0",
               err_at, bif.irq);
    end
    bif.IO_BotUpdt_Sync = 1'b0;
    repeat (5) @(negedge clk50);
    n_vec++;
    if (bif.ack_err !== 1'b1 || bif.irq !== 1'b0 || bif.IO_INT_ACK !== 1'b0) begin
      n_err++;
      $display("FAIL err_sticky: err=%b irq=%b ack=%b, expected 1 0 0", bif.ack_err, bif.irq, bif.IO_INT_ACK);
    end
  endtask

  task automatic test_async_reset();
    raise_update(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    expect_capture(2);
    @(negedge clk50);
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({bif.irq, bif.IO_INT_ACK, bif.ack_err, bif.snap_LocX, bif.snap_LocY,
         bif.snap_Sensors, bif.snap_BotInfo} !== '0) begin
      n_err++;
      $display("FAIL async_reset: irq=%b ack=%b err=%b snaps=%h%h%h%h, expected all 0 before any edge",
               bif.irq, bif.IO_INT_ACK, bif.ack_err, bif.snap_LocX, bif.snap_LocY,
               bif.snap_Sensors, bif.snap_BotInfo);
    end
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    miss_model = 0;
    raise_update(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    expect_capture(2);
    ack_and_clear();
    repeat (2) @(negedge clk50);
  endtask

  task automatic test_miss_cnt();
    pulse_updt(2);
    @(negedge clk50);
    check_miss("idle");
    raise_update(8'h01, 8'h02, 8'h03, 8'h04);
    expect_capture(2);
    pulse_updt(3);
    miss_model += 3;
    @(negedge clk50);
    check_miss("three");
    pulse_updt(300);
    miss_model = (miss_model + 300 > 255) ? 255 : miss_model + 300;
    @(negedge clk50);
    check_miss("saturate");
    ack_and_clear();
    repeat (2) @(negedge clk50);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_back_to_back();
    test_stuck_flag();
    test_async_reset();
    test_miss_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bot_int_ack_ctrl.md
Name: bot_int_ack_ctrl

Overview:
- Consumer/acknowledge end of the RojoBot update handshake.
- Watches the synchronized update flag IO_BotUpdt_Sync and snapshots the bot status bytes into shadow registers.
- Raises an interrupt request to the CPU and, once software signals it has read the snapshot, pulses IO_INT_ACK to clear the flag.
- Sits between the handshake flip-flop and the AHB-lite peripheral register file.

Parameters:
- CLR_TIMEOUT, 16: cycles WAIT_CLR waits for IO_BotUpdt_Sync to drop before re-issuing the ACK.
- MAX_RETRY, 3: number of ACK re-issues before the block gives up and flags an error.

Ports:
- clk50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- IO_BotUpdt_Sync  in  1  update-pending flag from the handshake flip-flop
- IO_BotUpdt  in  1  raw update pulse from the bot (used only with MISS_CNT_EN)
- LocX, LocY, Sensors, BotInfo  in  8 each  live bot status
- sw_ack_wr  in  1  one-cycle strobe: software has consumed the snapshot
- IO_INT_ACK  out  1  acknowledge to the handshake flip-flop
- irq  out  1  interrupt request to the CPU, level
- snap_LocX, snap_LocY, snap_Sensors, snap_BotInfo  out  8 each  captured status
- ack_err  out  1  sticky; set when the flag fails to clear after MAX_RETRY
- miss_cnt  out  8  updates lost while an update was pending (feature only)

Behaviour:
- Reset (async, immediate): state=IDLE; every output 0, including snapshots, ack_err and miss_cnt; retry and timeout counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE: if IO_BotUpdt_Sync==1, go to CAPTURE.
  - CAPTURE, 1 cycle: latch the four status bytes into snap_*; set irq=1; go to PENDING. irq is high 2 cycles after Sync rises.
  - PENDING: hold irq=1 and the snapshots stable. On sw_ack_wr: irq=0, go to ACK.
  - ACK, 1 cycle: IO_INT_ACK=1 (a single-cycle pulse); clear the timeout counter; go to WAIT_CLR.
  - WAIT_CLR: if Sync==0, go to IDLE and clear the retry count. Otherwise increment the timeout counter. When it reaches CLR_TIMEOUT-1:
    - retry count < MAX_RETRY: increment retry count, go to ACK.
    - otherwise: set ack_err=1, go to IDLE.
- Expected clear latency: the flip-flop samples the ACK at the next edge, so Sync reads 0 within 2 cycles of the ACK pulse.
- sw_ack_wr outside PENDING is ignored; no state change.
- If Sync is still 1 on return to IDLE (a new update arrived after the ACK was sampled), the next cycle enters CAPTURE. No update is lost.
- Snapshots change only in CAPTURE.
- ack_err is sticky until reset.
- Reset mid-PENDING: irq drops at once; the pending update is abandoned. The flip-flop still holds Sync=1, so the block re-captures after reset is released.
- Counter widths: timeout counter is $clog2(CLR_TIMEOUT) bits; retry counter is $clog2(MAX_RETRY+1) bits.

Optional Feature:
- Macro: BOT_MISS_CNT_EN.
- Defined: a rising edge on IO_BotUpdt while in CAPTURE, PENDING, ACK or WAIT_CLR increments miss_cnt. miss_cnt saturates at 255 and clears only on reset. IO_BotUpdt is delayed one register to detect the edge.
- Undefined: miss_cnt is tied to 0, IO_BotUpdt is unused, and no edge logic is built.

Decomposition:
- Package bot_int_pkg holds:
  - the state enum typedef: IDLE, CAPTURE, PENDING, ACK, WAIT_CLR;
  - the status byte width constant (8);
  - the miss_cnt saturation value (255).
- One sub-module is natural: bot_snap_reg, the 4x8 capture register with a load enable.
- FSM, counters and the miss counter stay in the top module.

Test Plan:
- Basic handshake: assert Sync with LocX=0x12, LocY=0x34, Sensors=0x5A, BotInfo=0x07 -> irq=1 two cycles later, snapshots hold those values. sw_ack_wr -> one-cycle IO_INT_ACK, irq=0. Model flip-flop drops Sync -> IDLE.
- Snapshot stability: change LocX to 0xFF while PENDING -> snap_LocX stays 0x12 until the next CAPTURE.
- Stuck flag: hold Sync=1 forever with CLR_TIMEOUT=16, MAX_RETRY=3 -> 4 ACK pulses spaced 17 cycles apart, then ack_err=1 and state IDLE.
- Back-to-back update: raise Sync again 1 cycle after the flip-flop clears -> second CAPTURE occurs, irq reasserts, no ACK is emitted without sw_ack_wr.
- Async reset: assert reset mid-PENDING -> irq, IO_INT_ACK and snap_* go to 0 without waiting for a clock edge. Release with Sync=1 -> re-capture.
- Miss counter (BOT_MISS_CNT_EN): 3 IO_BotUpdt pulses while PENDING -> miss_cnt=3. 300 pulses -> miss_cnt=255. Build without the macro -> miss_cnt=0.
